// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding, default widths and accumulator sizing for conv_mac_engine.
package conv_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned OUT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RD   = 3'd2,
        ST_AC   = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } conv_state_e;

    // Product width plus ADDR_W guard bits: up to 2^ADDR_W-1 terms can never overflow.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned addr_w);
        return 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered unsigned multiply-accumulate; clr has priority over en.
module conv_mac
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = acc_width(DATA_W_DEF, ADDR_W_DEF)
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [ACC_W-1:0]  acc
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_q;

    // Next accumulator value: clear, add one product, or hold.
    always_comb begin
        prod  = PROD_W'(x) * PROD_W'(y);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: Z[i] = sum_j X[j]*Y[i-j] over memX/memY, written to memZ, done pulse at end.
// Optional build macro CONV_SAT_EN: saturate Z words to OUT_W bits instead of truncating.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              en_s,
    input  logic              start,
    input  logic [ADDR_W-1:0] size_x,
    input  logic [ADDR_W-1:0] size_y,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_data,
    output logic [ADDR_W-1:0] y_addr,
    input  logic [DATA_W-1:0] y_data,
    output logic              rd_en,
    output logic              z_we,
    output logic [ADDR_W:0]   z_addr,
    output logic [OUT_W-1:0]  z_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned ACC_W = acc_width(DATA_W, ADDR_W);

    conv_state_e       state_q, state_d;
    logic [ADDR_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [CNT_W-1:0]  i_q, i_d, j_q, j_d, j_hi_q, j_hi_d;
    logic [ADDR_W-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d;
    logic              rd_en_q, rd_en_d, z_we_q, z_we_d;
    logic [CNT_W-1:0]  z_addr_q, z_addr_d;
    logic [OUT_W-1:0]  z_data_q, z_data_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [CNT_W-1:0]  sx_ext, sy_ext, i_last, i_inc, j_lo_c, j_hi_c;
    logic              empty_c;
    logic [ACC_W-1:0]  acc;
    logic              mac_clr, mac_en;

    // Output word formatting: saturate or keep the low OUT_W bits.
    function automatic logic [OUT_W-1:0] fmt(input logic [ACC_W-1:0] a);
`ifdef CONV_SAT_EN
        logic [ACC_W-1:0] out_max;
        out_max = ACC_W'((64'd1 << OUT_W) - 64'd1);
        if (a > out_max) begin
            return '1;
        end
        return OUT_W'(a);
`else
        return OUT_W'(a);
`endif
    endfunction

    // Accumulator is cleared in INIT and adds one product per AC cycle.
    assign mac_clr = en_s && (state_q == ST_INIT);
    assign mac_en  = en_s && (state_q == ST_AC);

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_a (rst_a),
        .clr   (mac_clr),
        .en    (mac_en),
        .x     (x_data),
        .y     (y_data),
        .acc   (acc)
    );

    // Term bounds for output i: j in [max(0, i-SY+1), min(i, SX-1)].
    always_comb begin
        sx_ext  = CNT_W'(sx_q);
        sy_ext  = CNT_W'(sy_q);
        i_last  = sx_ext + sy_ext - CNT_W'(2);
        i_inc   = i_q + CNT_W'(1);
        empty_c = (sx_q == '0) || (sy_q == '0);
        j_lo_c  = (i_inc > sy_ext) ? (i_inc - sy_ext) : '0;
        j_hi_c  = (i_q < sx_ext) ? i_q : (sx_ext - CNT_W'(1));
    end

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        i_d      = i_q;
        j_d      = j_q;
        j_hi_d   = j_hi_q;
        x_addr_d = x_addr_q;
        y_addr_d = y_addr_q;
        z_addr_d = z_addr_q;
        z_data_d = z_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sx_d    = size_x;
                    sy_d    = size_y;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = ST_INIT;
                end
            end
            // Empty check runs on the latched sizes, so an empty run is busy for this one cycle.
            ST_INIT: begin
                if (empty_c) begin
                    state_d = ST_DONE;
                end else begin
                    j_d     = j_lo_c;
                    j_hi_d  = j_hi_c;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_AC;
            end
            ST_AC: begin
                if (j_q == j_hi_q) begin
                    state_d = ST_WR;
                end else begin
                    j_d     = j_q + CNT_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (i_q == i_last) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_inc;
                    state_d = ST_INIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read strobe and addresses are valid during the RD state itself.
        rd_en_d = (state_d == ST_RD);
        if (state_d == ST_RD) begin
            x_addr_d = ADDR_W'(j_d);
            y_addr_d = ADDR_W'(i_q - j_d);
        end

        // The write is presented the cycle after WR, once the accumulator is final.
        z_we_d = (state_q == ST_WR);
        if (state_q == ST_WR) begin
            z_addr_d = i_q;
            z_data_d = fmt(acc);
        end

        busy_d = (state_d == ST_INIT) || (state_d == ST_RD) ||
                 (state_d == ST_AC)   || (state_d == ST_WR);
        done_d = (state_d == ST_DONE);
    end

    // State register; en_s low freezes everything.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q  <= ST_IDLE;
            sx_q     <= '0;
            sy_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            j_hi_q   <= '0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            rd_en_q  <= 1'b0;
            z_we_q   <= 1'b0;
            z_addr_q <= '0;
            z_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (en_s) begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            i_q      <= i_d;
            j_q      <= j_d;
            j_hi_q   <= j_hi_d;
            x_addr_q <= x_addr_d;
            y_addr_q <= y_addr_d;
            rd_en_q  <= rd_en_d;
            z_we_q   <= z_we_d;
            z_addr_q <= z_addr_d;
            z_data_q <= z_data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Strobes are masked while stalled so no memory access or pulse repeats.
    assign rd_en  = rd_en_q && en_s;
    assign z_we   = z_we_q && en_s;
    assign done   = done_q && en_s;
    assign x_addr = x_addr_q;
    assign y_addr = y_addr_q;
    assign z_addr = z_addr_q;
    assign z_data = z_data_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: directed checks of conv_mac_engine with behavioural memories.
module tb_conv_mac_engine;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OUT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_a, en_s, start;
    logic [ADDR_W-1:0] size_x, size_y;
    logic [ADDR_W-1:0] x_addr, y_addr;
    logic [DATA_W-1:0] x_data, y_data;
    logic              rd_en, z_we, busy, done;
    logic [ADDR_W:0]   z_addr;
    logic [OUT_W-1:0]  z_data;

    logic [DATA_W-1:0] x_mem [32];
    logic [DATA_W-1:0] y_mem [32];
    logic [OUT_W-1:0]  zmem  [64];
    int                wr_cnt, done_cnt, busy_cnt;
    logic              mon_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    conv_mac_engine #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk    (clk),
        .rst_a  (rst_a),
        .en_s   (en_s),
        .start  (start),
        .size_x (size_x),
        .size_y (size_y),
        .x_addr (x_addr),
        .x_data (x_data),
        .y_addr (y_addr),
        .y_data (y_data),
        .rd_en  (rd_en),
        .z_we   (z_we),
        .z_addr (z_addr),
        .z_data (z_data),
        .busy   (busy),
        .done   (done)
    );

    // Synchronous-read source memories, one cycle latency.
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= x_mem[x_addr];
            y_data <= y_mem[y_addr];
        end
    end

    // Destination memory plus write/done/busy counters.
    always @(posedge clk) begin
        if (mon_clr) begin
            wr_cnt   <= 0;
            done_cnt <= 0;
            busy_cnt <= 0;
            for (int k = 0; k < 64; k++) zmem[k] <= '0;
        end else begin
            if (z_we) begin
                zmem[z_addr] <= z_data;
                wr_cnt       <= wr_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    // Start one run and return start-to-done latency in cycles (-1 on timeout).
    task automatic run_conv(input int stall_at, input int stall_len, input bit hold, output int latency);
        int n;
        logic [ADDR_W-1:0] xa_hold;
        n       = 0;
        xa_hold = '0;
        latency = -1;
        start   = 1'b1;
        while (n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (!hold && n == 1) start = 1'b0;
            if (hold && n == 4) begin
                size_x = 5'd7;
                size_y = 5'd9;
            end
            if (hold && n == 8) start = 1'b0;
            if (hold && n == 9) start = 1'b1;
            if (stall_len > 0 && n == stall_at) begin
                en_s = 1'b0;
                #1;
                chk("stall_rd_en", 32'(rd_en), 32'd0);
                chk("stall_busy", 32'(busy), 32'd1);
                xa_hold = x_addr;
            end
            if (stall_len > 0 && n > stall_at && n < stall_at + stall_len)
                chk("stall_x_addr_hold", 32'(x_addr), 32'(xa_hold));
            if (stall_len > 0 && n == stall_at + stall_len) en_s = 1'b1;
            if (done) begin
                latency = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_small();
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd4; y_mem[1] = 8'd5;
        size_x = 5'd3;
        size_y = 5'd2;
    endtask

    task automatic check_small(input string tag);
        chk({tag, "_z0"}, 32'(zmem[0]), 32'd4);
        chk({tag, "_z1"}, 32'(zmem[1]), 32'd13);
        chk({tag, "_z2"}, 32'(zmem[2]), 32'd22);
        chk({tag, "_z3"}, 32'(zmem[3]), 32'd15);
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd4);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst_a   = 1'b0;
        en_s    = 1'b1;
        start   = 1'b0;
        size_x  = '0;
        size_y  = '0;
        mon_clr = 1'b0;
        for (int k = 0; k < 32; k++) begin
            x_mem[k] = '0;
            y_mem[k] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_z_we", 32'(z_we), 32'd0);
        chk("rst_z_addr", 32'(z_addr), 32'd0);
        chk("rst_z_data", 32'(z_data), 32'd0);
        chk("rst_x_addr", 32'(x_addr), 32'd0);

        // Basic 3x2 convolution
        load_small();
        clear_mon();
        run_conv(0, 0, 1'b0, lat);
        chk("a_latency", 32'(lat), 32'd21);
        chk("a_z_we_with_done", 32'(z_we), 32'd1);
        chk("a_busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("a_done_single", 32'(done), 32'd0);
        check_small("a");
        chk("a_busy_cycles", 32'(busy_cnt), 32'd20);

        // Empty X: no writes, short busy
        size_x = 5'd0;
        size_y = 5'd4;
        clear_mon();
        run_conv(0, 0, 1'b0, lat);
        chk("empty_latency", 32'(lat), 32'd2);
        repeat (3) @(posedge clk); #1;
        chk("empty_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("empty_busy_cycles", 32'(busy_cnt), 32'd1);
        chk("empty_done_cnt", 32'(done_cnt), 32'd1);

        // Stall 5 cycles mid-run
        load_small();
        clear_mon();
        run_conv(6, 5, 1'b0, lat);
        chk("stall_latency", 32'(lat), 32'd26);
        repeat (3) @(posedge clk); #1;
        check_small("stall");

        // Start held high, re-pulsed while busy, sizes changed mid-run
        load_small();
        clear_mon();
        run_conv(0, 0, 1'b1, lat);
        chk("hold_latency", 32'(lat), 32'd21);
        repeat (6) @(posedge clk); #1;
        check_small("hold");
        chk("hold_busy_idle", 32'(busy), 32'd0);

        // Reset during AC aborts the run
        load_small();
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_z_addr", 32'(z_addr), 32'd0);
        chk("abort_z_data", 32'(z_data), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("abort_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);

        // Clean run after abort
        clear_mon();
        run_conv(0, 0, 1'b0, lat);
        chk("rerun_latency", 32'(lat), 32'd21);
        repeat (3) @(posedge clk); #1;
        check_small("rerun");

        // Full-size run, all samples 0xFF
        for (int k = 0; k < 31; k++) begin
            x_mem[k] = 8'hFF;
            y_mem[k] = 8'hFF;
        end
        size_x = 5'd31;
        size_y = 5'd31;
        clear_mon();
        run_conv(0, 0, 1'b0, lat);
        chk("big_latency", 32'(lat), 32'd2045);
        repeat (3) @(posedge clk); #1;
        chk("big_wr_cnt", 32'(wr_cnt), 32'd61);
        chk("big_z0", 32'(zmem[0]), 32'hFE01);
        chk("big_z60", 32'(zmem[60]), 32'hFE01);
`ifdef CONV_SAT_EN
        chk("big_z1", 32'(zmem[1]), 32'hFFFF);
        chk("big_z30", 32'(zmem[30]), 32'hFFFF);
`else
        chk("big_z1", 32'(zmem[1]), 32'hFC02);
        chk("big_z30", 32'(zmem[30]), 32'hC21F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
